// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and the write-back queue entry type.
package regfile_pkg;
    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 16;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_fwd.sv
// regfile_wb_fwd: youngest-match search over queued write-back entries for one read port.
module regfile_wb_fwd
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0] ent_i,
    input  logic [DEPTH-1:0]      valid_i,
    input  logic [PTR_W-1:0]      head_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  hit_o,
    output logic [REG_DATA_W-1:0] data_o
);
    logic [PTR_W-1:0] idx;
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (valid_i[idx] && ent_i[idx].addr == rd_addr_i && rd_addr_i != REG_ZERO) begin
                hit_o  = 1'b1;
                data_o = ent_i[idx].data;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: two-port write-back queue feeding the regfile write port, with forwarding.
// Optional REGFILE_WB_BYPASS_EN lets an empty queue write the regfile in the push cycle.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in0_valid,
    input  logic [ADDR_W-1:0]   in0_addr,
    input  logic [DATA_W-1:0]   in0_data,
    output logic                in0_ready,
    input  logic                in1_valid,
    input  logic [ADDR_W-1:0]   in1_addr,
    input  logic [DATA_W-1:0]   in1_data,
    output logic                in1_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic                fwd_hit_a,
    output logic                fwd_hit_b,
    output logic [DATA_W-1:0]   fwd_data_a,
    output logic [DATA_W-1:0]   fwd_data_b,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W-1:0]    count
);
    wb_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, slot1;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] vld;
    logic ready, empty, p0, p1, byp0, byp1, enq0, enq1, pop;

    assign ready     = count_q <= CNT_W'(DEPTH - 2);
    assign in0_ready = ready;
    assign in1_ready = ready;
    assign count     = count_q;
    assign empty     = count_q == '0;
    assign p0        = in0_valid && ready && in0_addr != REG_ZERO && !flush;
    assign p1        = in1_valid && ready && in1_addr != REG_ZERO && !flush;
`ifdef REGFILE_WB_BYPASS_EN
    assign byp0 = empty && p0;
    assign byp1 = empty && !p0 && p1;
`else
    assign byp0 = 1'b0;
    assign byp1 = 1'b0;
`endif
    assign enq0  = p0 && !byp0;
    assign enq1  = p1 && !byp1;
    assign pop   = !empty && !flush;
    assign slot1 = tail_q + PTR_W'(enq0);

    assign wr_en   = pop || byp0 || byp1;
    assign wr_addr = byp0 ? in0_addr : byp1 ? in1_addr : ent_q[head_q].addr;
    assign wr_data = byp0 ? in0_data : byp1 ? in1_data : ent_q[head_q].data;

    always_comb begin
        ent_d = ent_q;
        if (enq0) ent_d[tail_q] = '{in0_addr, in0_data};
        if (enq1) ent_d[slot1] = '{in1_addr, in1_data};
        tail_d  = flush ? '0 : tail_q + PTR_W'(enq0) + PTR_W'(enq1);
        head_d  = flush ? '0 : head_q + PTR_W'(pop);
        count_d = flush ? '0 : count_q + CNT_W'(enq0) + CNT_W'(enq1) - CNT_W'(pop);
    end

    // Entry i is live when its distance from head is below the occupancy.
    always_comb begin
        vld     = '0;
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld[i] = {1'b0, PTR_W'(i) - head_q} < count_q;
            if (vld[i]) pending[ent_q[i].addr] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) ent_q <= ent_d;

    regfile_wb_fwd #(.DEPTH(DEPTH)) u_fwd_a (
        .ent_i(ent_q), .valid_i(vld), .head_i(head_q), .rd_addr_i(rd_addr_a),
        .hit_o(fwd_hit_a), .data_o(fwd_data_a)
    );

    regfile_wb_fwd #(.DEPTH(DEPTH)) u_fwd_b (
        .ent_i(ent_q), .valid_i(vld), .head_i(head_q), .rd_addr_i(rd_addr_b),
        .hit_o(fwd_hit_b), .data_o(fwd_data_b)
    );
endmodule
